seq_shift_add_multiplier: RTL and testbench
===========================================

// Module: seq_shift_add_multiplier
// PURPOSE
//  - 8x8 unsigned sequential shift-and-add multiplier, one partial product per clock.
//  - Upstream control/datapath stage for the team's 8-bit carry_lookahead_adder.
//  - Instantiates carry_lookahead_adder once: a=ACC, b=MCAND (cin internally 0).
//  - Registers the adder's s/cout back into the accumulator each iteration.
//  - Valid/ready handshake on both the operand and the product side.
// PARAMETERS
//  - WIDTH  8  operand width; fixed at 8 to match carry_lookahead_adder.
//  - CNT_W  3  iteration counter width; log2(WIDTH).
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   synchronous reset, active low
//  in_valid   in   1   operands a/b valid
//  in_ready   out  1   block can accept operands (high only in IDLE)
//  a          in   8   multiplicand, unsigned
//  b          in   8   multiplier, unsigned
//  out_valid  out  1   product p valid (high only in DONE)
//  out_ready  in   1   consumer takes p
//  p          out  16  product a*b
//  busy       out  1   high in RUN or DONE
// BEHAVIOUR
//  Clocking and reset
//  - One clock; reset is synchronous and active-low.
//  - rst_n low at an edge, any state including mid-RUN: state=IDLE, ACC=0, QR=0,
//    MCAND=0, R=0, cnt=0, C=0.
//  - Reset output values: in_ready=1, out_valid=0, busy=0, p=16'h0000.
//  Registers
//  - MCAND[7:0]: held multiplicand.
//  - ACC[7:0]: upper half of the running product.
//  - QR[7:0]: multiplier shifting out / product lower half shifting in.
//  - R[7:0]: copy of remaining multiplier bits.
//  - cnt[2:0]: iteration counter.
//  FSM states IDLE, RUN, DONE
//  - IDLE: in_ready=1.
//    - in_valid at an edge: MCAND=a, QR=b, R=b, ACC=0, cnt=0, go to RUN.
//  - RUN: each edge computes {C,ACC'} = QR[0] ? adder(ACC,MCAND) : {1'b0,ACC}.
//    - Then shift right: {ACC,QR} <= {C,ACC',QR[7:1]}.
//    - Also R <= R>>1 and cnt <= cnt+1.
//    - After the edge with cnt==7, go to DONE.
//  - DONE: out_valid=1; p and all registers frozen.
//    - out_ready at an edge: go to IDLE.
//  Data and arithmetic rules
//  - p = {ACC,QR} combinationally; checked only while out_valid=1.
//  - Adder cout becomes ACC[7] after the shift, so no overflow is possible:
//    max result 0xFF*0xFF = 0xFE01 fits in 16 bits.
//  Handshake rules
//  - in_valid is ignored in RUN and DONE; a/b may change freely after acceptance.
//  - out_valid holds until out_ready; p must not change while out_valid=1 and out_ready=0.
//  - in_ready is low in DONE, so the same-cycle out handshake plus new in-accept
//    cannot occur.
//  - The next accept is possible on the edge after the DONE->IDLE edge.
//  Latency and throughput
//  - out_valid rises exactly 8 edges after the accepting edge.
//  - Minimum initiation interval is 10 cycles.
// CONFIGURATION
//  - Macro MULT_EARLY_TERM_EN.
//  - Defined: in RUN, if R==0 at an edge, the remaining iterations add nothing.
//    - {ACC,QR} <= {ACC,QR} >> (8-cnt) in that edge; go to DONE.
//    - b=0 yields out_valid 1 edge after accept.
//    - b=0x01 yields out_valid 2 edges after accept.
//    - Latency = 1 + index of b's highest set bit + 1, capped at 8.
//  - Not defined: R logic removed; fixed 8-edge latency in all cases.
//  - Product values are identical in both builds.
// TESTING
//  1. Reset, then a=0xFF, b=0xFF: p=0xFE01; out_valid 8 edges after accept
//     (without MULT_EARLY_TERM_EN).
//  2. a=13, b=11: p=16'h008F; busy high from the accept edge until out handshake.
//  3. a=0x80, b=0x00: p=0x0000; latency 8 edges without the macro, 1 edge with it.
//  4. a=0x0F, b=0x02, out_ready held low 5 cycles after out_valid:
//     - p stays 0x001E; in_ready=0; a new in_valid is not accepted.
//     - Release out_ready: IDLE on the next edge.
//  5. rst_n low for one edge during RUN at cnt=4:
//     - Next cycle in_ready=1, out_valid=0, p=0.
//     - Then a=3, b=5 gives p=15.
//  6. Exhaustive sweep of all 65536 a/b pairs with random out_ready stalls:
//     - p==a*b for every pair in both macro builds.

Source files
------------

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/product handshake bundle for seq_shift_add_multiplier.
// master: the side that supplies operands and consumes the product.
// slave:  the multiplier itself.
interface seq_shift_add_multiplier_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] p;
   logic        busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, busy
   );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// 8x8 unsigned sequential shift-and-add multiplier, one partial product per clock.
// The accumulator adds through carry_lookahead_adder (a=ACC, b=MCAND, cin=0);
// the sum and carry-out are shifted back into {ACC,QR} every RUN cycle.
// Optional macro MULT_EARLY_TERM_EN: stop as soon as no multiplier bits remain,
// shifting the partial product into place in a single cycle.

module carry_lookahead_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);
   // Carry vector from generate/propagate terms; bit i is the carry into bit i.
   function automatic logic [8:0] cla_carries(input logic [7:0] g,
                                              input logic [7:0] pr,
                                              input logic       ci);
      logic [8:0] c;
      c[0] = ci;
      for (int i = 0; i < 8; i++) begin
         c[i+1] = g[i] | (pr[i] & c[i]);
      end
      return c;
   endfunction

   logic [7:0] gen_s;
   logic [7:0] prop_s;
   logic [8:0] carry_s;

   // Sum bits from propagate terms and lookahead carries.
   always_comb begin
      gen_s   = a & b;
      prop_s  = a ^ b;
      carry_s = cla_carries(gen_s, prop_s, cin);
      s       = prop_s ^ carry_s[7:0];
      cout    = carry_s[8];
   end
endmodule

module seq_shift_add_multiplier #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seq_shift_add_multiplier_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] qr_r;
   logic [CNT_W-1:0] cnt_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;

   logic [WIDTH-1:0]   sum_s;
   logic               cout_s;
   logic [WIDTH-1:0]   acc_add_s;
   logic               carry_add_s;
   logic [2*WIDTH-1:0] step_s;
   logic               last_iter_s;

`ifdef MULT_EARLY_TERM_EN
   logic [WIDTH-1:0]   r_r;
   logic [3:0]         shamt_s;
   logic [2*WIDTH-1:0] flush_s;
`endif

   carry_lookahead_adder u_cla (
      .a    (acc_r),
      .b    (mcand_r),
      .cin  (1'b0),
      .s    (sum_s),
      .cout (cout_s)
   );

   // One shift-and-add step: conditionally add MCAND, then shift {C,ACC,QR} right.
   always_comb begin
      if (qr_r[0]) begin
         acc_add_s   = sum_s;
         carry_add_s = cout_s;
      end else begin
         acc_add_s   = acc_r;
         carry_add_s = 1'b0;
      end
      step_s      = {carry_add_s, acc_add_s, qr_r[WIDTH-1:1]};
      last_iter_s = (cnt_r == 3'd7);
   end

`ifdef MULT_EARLY_TERM_EN
   // Once no multiplier bits remain, the rest of the iterations are pure shifts.
   always_comb begin
      shamt_s = 4'd8 - {1'b0, cnt_r};
      flush_s = {acc_r, qr_r} >> shamt_s;
   end
`endif

   // Next-state decode for IDLE -> RUN -> DONE -> IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
`ifdef MULT_EARLY_TERM_EN
            if ((r_r == 8'h00) || last_iter_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
`else
            if (last_iter_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_RUN;
            end
`endif
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and registered handshake/status flags derived from next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         in_ready_r  <= (state_nxt_s == ST_IDLE);
         out_valid_r <= (state_nxt_s == ST_DONE);
         busy_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DONE);
      end
   end

   // Operand capture, iteration datapath and counter; frozen outside RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_r <= 8'h00;
         acc_r   <= 8'h00;
         qr_r    <= 8'h00;
         cnt_r   <= 3'd0;
`ifdef MULT_EARLY_TERM_EN
         r_r     <= 8'h00;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  mcand_r <= bus.a;
                  qr_r    <= bus.b;
                  acc_r   <= 8'h00;
                  cnt_r   <= 3'd0;
`ifdef MULT_EARLY_TERM_EN
                  r_r     <= bus.b;
`endif
               end
            end
            ST_RUN: begin
`ifdef MULT_EARLY_TERM_EN
               if (r_r == 8'h00) begin
                  {acc_r, qr_r} <= flush_s;
               end else begin
                  {acc_r, qr_r} <= step_s;
               end
               r_r   <= r_r >> 1;
               cnt_r <= cnt_r + 3'd1;
`else
               {acc_r, qr_r} <= step_s;
               cnt_r         <= cnt_r + 3'd1;
`endif
            end
            ST_DONE: begin
               cnt_r <= cnt_r;
            end
            default: begin
               cnt_r <= 3'd0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.p         = {acc_r, qr_r};
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: directed cases plus random
// operand pairs with random output stalls, checked against a*b and the
// expected latency for the active build.
module tb_seq_shift_add_multiplier;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   seq_shift_add_multiplier_if mif ();

   seq_shift_add_multiplier dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected edges from accept to out_valid.
   function automatic int exp_latency(input logic [7:0] bv);
      int msb;
`ifdef MULT_EARLY_TERM_EN
      if (bv == 8'h00) return 1;
      msb = 0;
      for (int i = 0; i < 8; i++) if (bv[i]) msb = i;
      return (msb + 2 > 8) ? 8 : msb + 2;
`else
      msb = bv;
      return 8;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic [7:0] av, input logic [7:0] bv, input int stall);
      int n;
      int lat;
      logic [15:0] exp_p;
      exp_p = 16'(av) * 16'(bv);
      n = 0;
      while (!mif.in_ready && n < 30) begin
         tick();
         n++;
      end
      check("in_ready_before_accept", 32'(mif.in_ready), 32'd1);
      mif.in_valid = 1'b1;
      mif.a = av;
      mif.b = bv;
      tick();
      mif.in_valid = 1'b0;
      mif.a = 8'($urandom);
      mif.b = 8'($urandom);
      check("busy_after_accept", 32'(mif.busy), 32'd1);
      check("in_ready_after_accept", 32'(mif.in_ready), 32'd0);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!mif.out_valid && lat < 20);
      check("latency", 32'(lat), 32'(exp_latency(bv)));
      check("product", 32'(mif.p), 32'(exp_p));
      for (int i = 0; i < stall; i++) begin
         mif.in_valid = 1'b1;
         tick();
         check("stall_out_valid", 32'(mif.out_valid), 32'd1);
         check("stall_p_hold", 32'(mif.p), 32'(exp_p));
         check("stall_in_ready", 32'(mif.in_ready), 32'd0);
         check("stall_busy", 32'(mif.busy), 32'd1);
      end
      mif.in_valid  = 1'b0;
      mif.out_ready = 1'b1;
      tick();
      mif.out_ready = 1'b0;
      check("post_hs_out_valid", 32'(mif.out_valid), 32'd0);
      check("post_hs_in_ready", 32'(mif.in_ready), 32'd1);
      check("post_hs_busy", 32'(mif.busy), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      mif.in_valid  = 1'b0;
      mif.a         = 8'h00;
      mif.b         = 8'h00;
      mif.out_ready = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", 32'(mif.in_ready), 32'd1);
      check("rst_out_valid", 32'(mif.out_valid), 32'd0);
      check("rst_busy", 32'(mif.busy), 32'd0);
      check("rst_p", 32'(mif.p), 32'h0000);
      rst_n = 1'b1;
      tick();

      run_txn(8'hFF, 8'hFF, 0);
      run_txn(8'd13, 8'd11, 1);
      run_txn(8'h80, 8'h00, 0);
      run_txn(8'h0F, 8'h02, 5);
      run_txn(8'hA5, 8'h01, 0);
      run_txn(8'h00, 8'hFF, 2);
      run_txn(8'hFF, 8'h80, 0);

      // Reset in the middle of RUN with cnt at 4.
      mif.in_valid = 1'b1;
      mif.a = 8'h77;
      mif.b = 8'hFF;
      tick();
      mif.in_valid = 1'b0;
      repeat (4) tick();
      check("mid_run_busy", 32'(mif.busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_in_ready", 32'(mif.in_ready), 32'd1);
      check("midrst_out_valid", 32'(mif.out_valid), 32'd0);
      check("midrst_busy", 32'(mif.busy), 32'd0);
      check("midrst_p", 32'(mif.p), 32'h0000);
      run_txn(8'd3, 8'd5, 0);

      for (int k = 0; k < 500; k++) begin
         run_txn(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
